// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state encoding for the serial arithmetic blocks
package serial_subtractor_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_subtractor_fs.sv
// full_subtractor: combinational A-B-Bin cell built from two half subtractors and an OR
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);
  assign d  = a ^ b;
  assign bo = ~a & b;
endmodule

module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  logic w_d1, w_b1, w_b2;
  half_subtractor u_hs0 (.a(A), .b(B), .d(w_d1), .bo(w_b1));
  half_subtractor u_hs1 (.a(w_d1), .b(Bin), .d(D), .bo(w_b2));
  assign Bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B - Bin, LSB first, one bit per clock; busy/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_opa, r_opb, r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             w_d, w_br;
  full_subtractor u_fs (.A(r_opa[0]), .B(r_opb[0]), .Bin(r_br), .D(w_d), .Bout(w_br));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      D       <= '0;
      Bout    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_opa <= r_opa >> 1;
          r_opb <= r_opb >> 1;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_br  <= w_br;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            D       <= {w_d, r_res[WIDTH-1:1]};
            Bout    <= w_br;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            r_state <= ST_RUN;
            r_opa   <= A;
            r_opb   <= B;
            r_br    <= Bin;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random + directed checks of serial_subtractor (WIDTH 8 and 2) against a behavioural model
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic st8 = 1'b0, bi8 = 1'b0, st2 = 1'b0, bi2 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] a2 = '0, b2 = '0;
  logic busy8, done8, bo8, busy2, done2, bo2;
  logic [7:0] d8;
  logic [1:0] d2;
  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8), .Bin(bi8),
    .busy(busy8), .done(done8), .D(d8), .Bout(bo8));
  serial_subtractor #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .start(st2), .A(a2), .B(b2), .Bin(bi2),
    .busy(busy2), .done(done2), .D(d2), .Bout(bo2));
  int checks = 0;
  int failures = 0;
  function automatic void chk(string name, logic [64:0] got, logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 50) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction
  function automatic logic [64:0] ref_sub(int w, logic [63:0] a, logic [63:0] b, bit bi);
    logic [64:0] m;
    m = (65'd1 << (w + 1)) - 65'd1;
    return ({1'b0, a} - {1'b0, b} - 65'(bi)) & m;
  endfunction
  int left[2] = '{0, 0};
  logic m_busy[2] = '{1'b0, 1'b0};
  logic m_done[2] = '{1'b0, 1'b0};
  logic [64:0] m_res[2] = '{65'd0, 65'd0};
  logic [64:0] pend[2] = '{65'd0, 65'd0};
  bit armed = 1'b0;
  task automatic step(int i, int w, bit s, logic [63:0] a, logic [63:0] b, bit bi);
    if (left[i] > 0) begin
      left[i]--;
      if (left[i] == 0) begin
        m_done[i] = 1'b1;
        m_busy[i] = 1'b0;
        m_res[i]  = pend[i];
      end
    end else begin
      m_done[i] = 1'b0;
      if (s) begin
        pend[i]   = ref_sub(w, a, b, bi);
        left[i]   = w;
        m_busy[i] = 1'b1;
      end
    end
  endtask
  always @(posedge clk) begin
    armed = 1'b1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        left[i] = 0;
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_res[i] = '0;
      end
    end else begin
      step(0, 8, st8, 64'(a8), 64'(b8), bi8);
      step(1, 2, st2, 64'(a2), 64'(b2), bi2);
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("w8_busy", 65'(busy8), 65'(m_busy[0]));
      chk("w8_done", 65'(done8), 65'(m_done[0]));
      chk("w8_result", 65'({bo8, d8}), m_res[0]);
      chk("w8_busy_and_done", 65'(busy8 & done8), 65'd0);
      chk("w2_busy", 65'(busy2), 65'(m_busy[1]));
      chk("w2_done", 65'(done2), 65'(m_done[1]));
      chk("w2_result", 65'({bo2, d2}), m_res[1]);
      chk("w2_busy_and_done", 65'(busy2 & done2), 65'd0);
    end
  end
  task automatic op8(logic [7:0] a, logic [7:0] b, logic bi, logic [7:0] ed, logic eb);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; bi8 = bi; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    n = 1;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("op8_latency", 65'(n), 65'd9);
    chk("op8_value", 65'({bo8, d8}), 65'({eb, ed}));
  endtask
  task automatic op2(logic [1:0] a, logic [1:0] b, logic bi, logic [2:0] e);
    int n;
    @(negedge clk);
    a2 = a; b2 = b; bi2 = bi; st2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0;
    n = 1;
    while (!done2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("op2_latency", 65'(n), 65'd3);
    chk("op2_value", 65'({bo2, d2}), 65'(e));
  endtask
  initial begin
    int n, nd;
    int t[3];
    repeat (2) @(negedge clk);
    chk("reset_busy", 65'(busy8), 65'd0);
    chk("reset_done", 65'(done8), 65'd0);
    chk("reset_D", 65'({bo8, d8}), 65'd0);
    rst = 1'b0;
    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    a8 = 8'h20; b8 = 8'h05; bi8 = 1'b0; st8 = 1'b1;
    nd = 0;
    for (n = 1; n <= 16; n++) begin
      @(negedge clk);
      st8 = 1'b0;
      if (n == 2 || n == 4) begin
        st8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
      end
      if (done8) begin
        nd++;
        chk("ignore_done_time", 65'(n), 65'd9);
      end
    end
    chk("ignore_done_count", 65'(nd), 65'd1);
    chk("ignore_value", 65'({bo8, d8}), 65'h01B);
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; bi8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 65'(busy8), 65'd0);
    chk("abort_done", 65'(done8), 65'd0);
    chk("abort_D", 65'({bo8, d8}), 65'd0);
    rst = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("abort_no_done", 65'(nd), 65'd0);
    op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bi8 = 1'b0; st8 = 1'b1;
    nd = 0;
    for (n = 1; n <= 40 && nd < 3; n++) begin
      @(negedge clk);
      if (done8) begin
        t[nd] = n;
        nd++;
        chk("b2b_value", 65'({bo8, d8}), 65'h022);
      end
    end
    st8 = 1'b0;
    chk("b2b_count", 65'(nd), 65'd3);
    chk("b2b_spacing1", 65'(t[1] - t[0]), 65'd9);
    chk("b2b_spacing2", 65'(t[2] - t[1]), 65'd9);
    repeat (12) @(negedge clk);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          op2(2'(a), 2'(b), 1'(c), 3'((a - b - c) & 7));
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      a2 = 2'($urandom); b2 = 2'($urandom); bi2 = 1'($urandom);
      st8 = ($urandom_range(0, 9) < 6);
      st2 = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0; st8 = 1'b0; st2 = 1'b0;
    repeat (12) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
